icache_storage_nway: RTL
========================

# icache_storage_nway

Parametrised N-way set-associative tag/data storage for the instruction cache, the next generation of the direct-mapped storage array. It sits between the icache controller and the CPU fetch port. It performs a registered lookup across all ways of a set and installs refill blocks using true-LRU victim selection. A multi-cycle flush sweep invalidates the whole array.

## Interface
- BLOCK_SIZE, 4: words per block; power of two, at least 1.
- WORD_WIDTH, 32: bits per word.
- INDEX_BITS, 4: number of sets is 2^INDEX_BITS.
- WAYS, 2: associativity; power of two, 1 to 8.
- Derived values:
  - OFFSET_BITS = clog2(BLOCK_SIZE), or 0 when BLOCK_SIZE is 1.
  - TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS.
  - Addresses are word addresses: offset = address[OFFSET_BITS-1:0], index is the next INDEX_BITS bits, tag is the remaining upper bits.

Ports:
- clk  in  1  clock. One clock domain.
- reset  in  1  synchronous, active-high reset.
- read  in  1  lookup request, sampled at posedge.
- write  in  1  fill request; installs write_block at address's set.
- flush  in  1  single-cycle pulse requesting invalidate-all.
- address  in  32  CPU word address (read and write).
- write_block  in  WORD_WIDTH*BLOCK_SIZE  refill block; word i is at bits [i*WORD_WIDTH +: WORD_WIDTH].
- read_data  out  WORD_WIDTH  looked-up word; 0 on miss.
- hit  out  1  lookup result, qualified by read_valid.
- read_valid  out  1  high for one cycle when a lookup completes.
- busy  out  1  flush sweep in progress.
- fill_way  out  clog2(WAYS), minimum 1  way written by the most recent fill.

## Operation
- Per way and set: valid bit, tag, BLOCK_SIZE words, and an age counter of clog2(WAYS) bits.
- Lookup: compare tag against all valid ways of the indexed set.
  - Hit: read_data is the word at offset in the matching way, and that way is made MRU.
  - Miss: read_data = 0. Ages are unchanged.
- Fill way selection:
  - If any way in the set already holds the tag, overwrite that way. There are never duplicate tags in a set.
  - Otherwise take the lowest-numbered invalid way.
  - Otherwise take the way with age WAYS-1 (the LRU way).
- Fill writes valid=1, the tag, all words, and sets fill_way. The written way becomes MRU.
- MRU update for way w: every way in the set with age < age[w] increments, then age[w] becomes 0. Ages within a set remain a permutation of 0..WAYS-1.
- Same cycle read and write:
  - Both are accepted.
  - The read sees the pre-write contents.
  - If both target the same set, only the write's LRU update is applied.
- Flush FSM states:
  - IDLE: when flush=1, go to SWEEP with the set counter at 0.
  - SWEEP: each cycle, clear all valid bits of the counted set and reset its ages to age[w]=w, then increment the counter. After set 2^INDEX_BITS-1 is cleared, return to IDLE.
- While busy:
  - read and write are ignored; no read_valid is produced.
  - flush pulses are ignored.
- A flush pulse in the same cycle as read or write starts the sweep and drops the read and the write.
- Data words are not cleared by reset or flush. Only valid bits and ages are cleared.

## Timing
- Reset (synchronous): all valid=0, age[w]=w in every set, FSM IDLE, counter 0. read_data=0, hit=0, read_valid=0, busy=0, fill_way=0.
- Reset asserted mid-sweep aborts the sweep. The array is fully invalid after reset regardless.
- Lookup latency is 1 cycle. A read at edge N gives read_valid, hit and read_data valid after edge N.
- read_valid is 0 in every cycle without an accepted read. hit and read_data hold their last values in those cycles.
- A fill takes effect at its edge. A read in the following cycle sees the new block.
- busy rises the cycle after the flush edge and stays high for exactly 2^INDEX_BITS cycles.
- The first read is accepted at the edge where busy is sampled 0.
- Back-to-back reads are supported, one per cycle, at full throughput.

## Test plan
All scenarios use the default parameters: index 4 corresponds to addresses 0x10, 0x50 and 0x90, with tags 0, 1 and 2.
- Reset, then read 0x10: next cycle read_valid=1, hit=0, read_data=0.
- Write 0x10 with word0..3 = 0xA0,0xA1,0xA2,0xA3, then read 0x12: hit=1, read_data=0xA2, fill_way=0.
- LRU eviction:
  - Stimulus: fill 0x10 (fill_way=0), fill 0x50 (fill_way=1), read 0x10 (hit), then fill 0x90.
  - Required: the 0x90 fill gives fill_way=1. Then read 0x50 misses, read 0x10 hits, read 0x90 hits.
- Refill of a resident tag: fill 0x10 twice with different data. Both fills give fill_way=0, and a read returns the second block's word.
- Flush after the fills:
  - busy stays high for 16 cycles.
  - A read issued during busy gives no read_valid.
  - After busy falls, reads of 0x10 and 0x50 give hit=0.
- Mixed cases:
  - Same-cycle read and write of 0x20: read gives hit=0; a read the next cycle gives hit=1.
  - Reset asserted in the 5th sweep cycle: busy=0 next cycle, and all reads miss.

Source files
------------

// File: rtl/icache_storage_nway_if.sv
// icache storage bus: lookup, fill and flush requests
// plus registered lookup results and sweep status.
interface icache_storage_nway_if #(
  parameter int WORD_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int WAYS       = 2
);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                             read;
  logic                             write;
  logic                             flush;
  logic [31:0]                      address;
  logic [WORD_WIDTH*BLOCK_SIZE-1:0] write_block;
  logic [WORD_WIDTH-1:0]            read_data;
  logic                             hit;
  logic                             read_valid;
  logic                             busy;
  logic [WW-1:0]                    fill_way;

  modport master (
    output read, write, flush, address, write_block,
    input  read_data, hit, read_valid, busy, fill_way
  );

  modport slave (
    input  read, write, flush, address, write_block,
    output read_data, hit, read_valid, busy, fill_way
  );
endinterface

// File: rtl/icache_storage_nway.sv
// N-way set-associative icache tag/data storage with
// true-LRU fills, registered lookup and a flush sweep.
module icache_storage_nway #(
  parameter int BLOCK_SIZE = 4,
  parameter int WORD_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  icache_storage_nway_if.slave  bus
);
  localparam int SETS = 1 << INDEX_BITS;
  localparam int OB   = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 0;
  localparam int OW   = (OB > 0) ? OB : 1;
  localparam int TB   = 32 - INDEX_BITS - OB;
  localparam int AW   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int BW   = WORD_WIDTH * BLOCK_SIZE;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t                state_q;
  logic [INDEX_BITS-1:0] cnt_q;
  logic                  valid_q [SETS][WAYS];
  logic [TB-1:0]         tag_q   [SETS][WAYS];
  logic [BW-1:0]         data_q  [SETS][WAYS];
  logic [AW-1:0]         age_q   [SETS][WAYS];

  logic [WORD_WIDTH-1:0] rdata_q;
  logic                  hit_q;
  logic                  rvalid_q;
  logic                  busy_q;
  logic [AW-1:0]         fway_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TB-1:0]         tag;
  logic [OW-1:0]         off;

  assign idx = bus.address[OB +: INDEX_BITS];
  assign tag = bus.address[31 -: TB];
  assign off = OW'(bus.address & 32'(BLOCK_SIZE - 1));

  logic idle;
  logic rd_en;
  logic wr_en;

  // A flush pulse wins over read/write; nothing is accepted mid-sweep.
  assign idle  = (state_q == IDLE);
  assign rd_en = bus.read  && idle && !bus.flush;
  assign wr_en = bus.write && idle && !bus.flush;

  logic [WAYS-1:0]       match;
  logic [AW-1:0]         hway;
  logic                  hit_c;
  logic [WORD_WIDTH-1:0] word_c;

  // Tag compare across all valid ways of the indexed set.
  always_comb begin
    match = '0;
    hway  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        match[w] = 1'b1;
        hway     = AW'(w);
      end
    end
    hit_c  = |match;
    word_c = data_q[idx][hway][int'(off)*WORD_WIDTH +: WORD_WIDTH];
  end

  logic          inv_found;
  logic [AW-1:0] inv_way;
  logic [AW-1:0] lru_way;
  logic [AW-1:0] fway_c;

  // Victim choice: resident tag, else lowest invalid, else LRU.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = AW'(w);
      end
      if (age_q[idx][w] == AW'(WAYS - 1)) begin
        lru_way = AW'(w);
      end
    end
    if (hit_c) begin
      fway_c = hway;
    end else if (inv_found) begin
      fway_c = inv_way;
    end else begin
      fway_c = lru_way;
    end
  end

  logic          mru_en;
  logic [AW-1:0] mru_way;
  logic [AW-1:0] age_d [WAYS];

  // Read and write share one address, so a fill's LRU
  // update always supersedes a same-cycle hit's.
  always_comb begin
    mru_en  = wr_en || (rd_en && hit_c);
    mru_way = wr_en ? fway_c : hway;
    for (int v = 0; v < WAYS; v++) begin
      if (AW'(v) == mru_way) begin
        age_d[v] = '0;
      end else if (age_q[idx][v] < age_q[idx][mru_way]) begin
        age_d[v] = age_q[idx][v] + 1'b1;
      end else begin
        age_d[v] = age_q[idx][v];
      end
    end
  end

  // Control state: valid/tag/age arrays, results, flush FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      rdata_q  <= '0;
      fway_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          age_q[s][w]   <= AW'(w);
        end
      end
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) begin
        hit_q   <= hit_c;
        rdata_q <= hit_c ? word_c : '0;
      end
      if (wr_en) begin
        valid_q[idx][fway_c] <= 1'b1;
        tag_q[idx][fway_c]   <= tag;
        fway_q               <= fway_c;
      end
      if (mru_en) begin
        for (int v = 0; v < WAYS; v++) begin
          age_q[idx][v] <= age_d[v];
        end
      end
      unique case (state_q)
        IDLE: begin
          if (bus.flush) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[cnt_q][w] <= 1'b0;
            age_q[cnt_q][w]   <= AW'(w);
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == INDEX_BITS'(SETS - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  // Block data is never cleared, only overwritten by fills.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[idx][fway_c] <= bus.write_block;
    end
  end

  assign bus.read_data  = rdata_q;
  assign bus.hit        = hit_q;
  assign bus.read_valid = rvalid_q;
  assign bus.busy       = busy_q;
  assign bus.fill_way   = fway_q;
endmodule
